// File: rtl/line_follow_pkg.sv
// Shared encodings for the line-following steering controller: FSM states,
// tracker road codes and the last-turn flag, plus the road-code decoder.
package line_follow_pkg;

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StFwd    = 3'd1;
   localparam logic [2:0] StLeft   = 3'd2;
   localparam logic [2:0] StRight  = 3'd3;
   localparam logic [2:0] StSearch = 3'd4;
   localparam logic [2:0] StStop   = 3'd5;

   // Road codes are {left, mid, right}, 1 = line under that sensor.
   localparam logic [2:0] RoadNone     = 3'b000;
   localparam logic [2:0] RoadRight    = 3'b001;
   localparam logic [2:0] RoadMid      = 3'b010;
   localparam logic [2:0] RoadMidRight = 3'b011;
   localparam logic [2:0] RoadLeft     = 3'b100;
   localparam logic [2:0] RoadSplit    = 3'b101;
   localparam logic [2:0] RoadLeftMid  = 3'b110;
   localparam logic [2:0] RoadAll      = 3'b111;

   localparam logic TurnLeft  = 1'b0;
   localparam logic TurnRight = 1'b1;

   // The split code (101) is ambiguous, so the current heading is kept.
   function automatic logic [2:0] decode_road(input logic [2:0] road, input logic [2:0] cur);
      logic [2:0] st;
      case (road)
         RoadMid, RoadAll:         st = StFwd;
         RoadLeft, RoadLeftMid:    st = StLeft;
         RoadRight, RoadMidRight:  st = StRight;
         RoadNone:                 st = StSearch;
         default:                  st = (cur == StIdle) ? StFwd : cur;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/road_debounce.sv
// Debounces the 3-bit tracker code: a value is accepted once it has been
// sampled unchanged on STABLE_CYCLES consecutive clock edges.
module road_debounce
   import line_follow_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] din,
   output logic [2:0] dout
);

   localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   logic [2:0]      cand_q, cand_d;
   logic [2:0]      road_q, road_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // cnt_d counts the current sample, so acceptance happens on the Nth edge.
   always_comb begin
      cand_d = din;
      road_d = road_q;
      if (din != cand_q) begin
         cnt_d = CntOne;
      end else if (cnt_q == CntMax) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CntOne;
      end
      if (cnt_d == CntMax) begin
         road_d = din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cand_q <= RoadNone;
         road_q <= RoadNone;
         cnt_q  <= '0;
      end else begin
         cand_q <= cand_d;
         road_q <= road_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout = road_q;

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following steering controller: debounced tracker code drives a
// forward/correct/search/stop FSM with registered wheel-motor commands.
module line_follow_ctrl
   import line_follow_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned LOST_TIMEOUT  = 50_000_000,
   parameter logic [9:0]  SPEED_FWD     = 10'd800,
   parameter logic [9:0]  SPEED_SLOW    = 10'd400,
   parameter logic [9:0]  SPEED_PIVOT   = 10'd500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [2:0] detect_road,
   output logic [9:0] left_speed,
   output logic [9:0] right_speed,
   output logic       left_dir,
   output logic       right_dir,
   output logic [2:0] state_o,
   output logic       lost
);

   localparam int unsigned LostW = $clog2(LOST_TIMEOUT + 1);
   localparam logic [LostW-1:0] LostLast = LostW'(LOST_TIMEOUT - 1);
   localparam logic [LostW-1:0] LostOne  = LostW'(1);

   logic [2:0]       road_q;
   logic [2:0]       dec;
   logic [2:0]       state_q, state_d;
   logic             last_turn_q, last_turn_d;
   logic [LostW-1:0] lost_cnt_q, lost_cnt_d;
   logic [9:0]       left_speed_q, left_speed_d, right_speed_q, right_speed_d;
   logic             left_dir_q, left_dir_d, right_dir_q, right_dir_d;
   logic             lost_q, lost_d;

   road_debounce #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .din  (detect_road),
      .dout (road_q)
   );

   // Finding the line again takes priority over the lost-line timeout.
   always_comb begin
      dec     = decode_road(road_q, state_q);
      state_d = state_q;
      if (!enable) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle, StFwd, StLeft, StRight: state_d = dec;
            StSearch: begin
               if (dec != StSearch) begin
                  state_d = dec;
               end else if (lost_cnt_q == LostLast) begin
                  state_d = StStop;
               end
            end
            StStop:  state_d = StStop;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      lost_cnt_d = '0;
      if (state_q == StSearch && state_d == StSearch) begin
         lost_cnt_d = lost_cnt_q + LostOne;
      end
      last_turn_d = last_turn_q;
      if (state_d == StLeft) begin
         last_turn_d = TurnLeft;
      end else if (state_d == StRight) begin
         last_turn_d = TurnRight;
      end
   end

   // Commands are decoded from the next state so they change with state_o.
   always_comb begin
      left_speed_d  = '0;
      right_speed_d = '0;
      left_dir_d    = 1'b1;
      right_dir_d   = 1'b1;
      lost_d        = (state_d == StStop);
      case (state_d)
         StFwd: begin
            left_speed_d  = SPEED_FWD;
            right_speed_d = SPEED_FWD;
         end
         StLeft: begin
            left_speed_d  = SPEED_SLOW;
            right_speed_d = SPEED_FWD;
         end
         StRight: begin
            left_speed_d  = SPEED_FWD;
            right_speed_d = SPEED_SLOW;
         end
         StSearch: begin
            left_speed_d  = SPEED_PIVOT;
            right_speed_d = SPEED_PIVOT;
            left_dir_d    = (last_turn_d == TurnRight);
            right_dir_d   = (last_turn_d == TurnLeft);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         last_turn_q   <= TurnLeft;
         lost_cnt_q    <= '0;
         left_speed_q  <= '0;
         right_speed_q <= '0;
         left_dir_q    <= 1'b1;
         right_dir_q   <= 1'b1;
         lost_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_turn_q   <= last_turn_d;
         lost_cnt_q    <= lost_cnt_d;
         left_speed_q  <= left_speed_d;
         right_speed_q <= right_speed_d;
         left_dir_q    <= left_dir_d;
         right_dir_q   <= right_dir_d;
         lost_q        <= lost_d;
      end
   end

   assign state_o     = state_q;
   assign left_speed  = left_speed_q;
   assign right_speed = right_speed_q;
   assign left_dir    = left_dir_q;
   assign right_dir   = right_dir_q;
   assign lost        = lost_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Scoreboard bench for line_follow_ctrl: expected command sets are queued with
// a due cycle when stimulus is applied and compared when that cycle arrives.
module tb_line_follow_ctrl;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [2:0] detect_road;
   logic [9:0] left_speed, right_speed;
   logic       left_dir, right_dir;
   logic [2:0] state_o;
   logic       lost;

   typedef struct {
      int         due;
      string      tag;
      logic [2:0] st;
      logic [9:0] ls;
      logic [9:0] rs;
      logic       ld;
      logic       rd;
      logic       lo;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   line_follow_ctrl #(
      .STABLE_CYCLES(4),
      .LOST_TIMEOUT (16),
      .SPEED_FWD    (10'd800),
      .SPEED_SLOW   (10'd400),
      .SPEED_PIVOT  (10'd500)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .detect_road(detect_road),
      .left_speed (left_speed),
      .right_speed(right_speed),
      .left_dir   (left_dir),
      .right_dir  (right_dir),
      .state_o    (state_o),
      .lost       (lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_exp(input int lat, input string tag, input logic [2:0] st,
                           input logic [9:0] ls, input logic [9:0] rs,
                           input logic ld, input logic rd, input logic lo);
      exp_t e;
      e.due = cyc + lat;
      e.tag = tag;
      e.st  = st;
      e.ls  = ls;
      e.rs  = rs;
      e.ld  = ld;
      e.rd  = rd;
      e.lo  = lo;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk_val({tag, ".st"}, state_o, 0);
      chk_val({tag, ".ls"}, left_speed, 0);
      chk_val({tag, ".rs"}, right_speed, 0);
      chk_val({tag, ".ld"}, left_dir, 1);
      chk_val({tag, ".rd"}, right_dir, 1);
      chk_val({tag, ".lost"}, lost, 0);
   endtask

   always @(negedge clk) begin
      while (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
         mon_e = exp_q.pop_front();
         if (mon_e.due != cyc) chk_val({mon_e.tag, ".late"}, cyc, mon_e.due);
         chk_val({mon_e.tag, ".st"}, state_o, mon_e.st);
         chk_val({mon_e.tag, ".ls"}, left_speed, mon_e.ls);
         chk_val({mon_e.tag, ".rs"}, right_speed, mon_e.rs);
         chk_val({mon_e.tag, ".ld"}, left_dir, mon_e.ld);
         chk_val({mon_e.tag, ".rd"}, right_dir, mon_e.rd);
         chk_val({mon_e.tag, ".lost"}, lost, mon_e.lo);
      end
   end

   initial begin
      reset       = 1'b1;
      enable      = 1'b1;
      detect_road = 3'b010;
      #1 reset = 1'b0;
      #1 chk_reset_vals("reset");
      #10 reset = 1'b1;

      // Start-up: empty road_q looks like a lost line until 010 is accepted.
      push_exp(4, "start_e4", 3'd4, 10'd500, 10'd500, 1'b0, 1'b1, 1'b0);
      push_exp(5, "start_e5", 3'd1, 10'd800, 10'd800, 1'b1, 1'b1, 1'b0);
      tick(5);

      detect_road = 3'b110;
      push_exp(3, "glitch", 3'd1, 10'd800, 10'd800, 1'b1, 1'b1, 1'b0);
      tick(3);
      detect_road = 3'b010;
      push_exp(3, "glitch_after", 3'd1, 10'd800, 10'd800, 1'b1, 1'b1, 1'b0);
      tick(2);
      detect_road = 3'b110;
      push_exp(4, "left_e4", 3'd1, 10'd800, 10'd800, 1'b1, 1'b1, 1'b0);
      push_exp(5, "left_e5", 3'd2, 10'd400, 10'd800, 1'b1, 1'b1, 1'b0);
      tick(5);

      detect_road = 3'b011;
      push_exp(4, "right_e4", 3'd2, 10'd400, 10'd800, 1'b1, 1'b1, 1'b0);
      push_exp(5, "right_e5", 3'd3, 10'd800, 10'd400, 1'b1, 1'b1, 1'b0);
      tick(5);

      detect_road = 3'b000;
      push_exp(4, "srch_r_e4", 3'd3, 10'd800, 10'd400, 1'b1, 1'b1, 1'b0);
      push_exp(5, "srch_r", 3'd4, 10'd500, 10'd500, 1'b1, 1'b0, 1'b0);
      push_exp(20, "srch_last", 3'd4, 10'd500, 10'd500, 1'b1, 1'b0, 1'b0);
      push_exp(21, "stop", 3'd5, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
      tick(21);
      detect_road = 3'b010;
      push_exp(10, "stop_sticky", 3'd5, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
      tick(10);

      enable = 1'b0;
      push_exp(1, "stop_idle", 3'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
      tick(1);
      enable = 1'b1;
      push_exp(1, "rerun_fwd", 3'd1, 10'd800, 10'd800, 1'b1, 1'b1, 1'b0);
      tick(1);
      detect_road = 3'b110;
      push_exp(5, "left2", 3'd2, 10'd400, 10'd800, 1'b1, 1'b1, 1'b0);
      tick(5);
      detect_road = 3'b000;
      push_exp(5, "srch_l", 3'd4, 10'd500, 10'd500, 1'b0, 1'b1, 1'b0);
      tick(16);
      // 010 reaches road_q one edge before the timeout edge.
      detect_road = 3'b010;
      push_exp(4, "race_srch", 3'd4, 10'd500, 10'd500, 1'b0, 1'b1, 1'b0);
      push_exp(5, "race_fwd", 3'd1, 10'd800, 10'd800, 1'b1, 1'b1, 1'b0);
      tick(5);

      detect_road = 3'b101;
      push_exp(5, "split_hold", 3'd1, 10'd800, 10'd800, 1'b1, 1'b1, 1'b0);
      tick(5);
      enable = 1'b0;
      push_exp(1, "fwd_idle", 3'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
      tick(1);
      enable = 1'b1;
      push_exp(1, "split_idle", 3'd1, 10'd800, 10'd800, 1'b1, 1'b1, 1'b0);
      tick(1);

      detect_road = 3'b000;
      push_exp(5, "srch_pre_rst", 3'd4, 10'd500, 10'd500, 1'b0, 1'b1, 1'b0);
      tick(5);
      @(negedge clk);
      #1 reset = 1'b0;
      #1 chk_reset_vals("async_rst");
      #2;
      detect_road = 3'b010;
      reset       = 1'b1;
      tick(1);
      push_exp(3, "rst_e4", 3'd4, 10'd500, 10'd500, 1'b0, 1'b1, 1'b0);
      push_exp(4, "rst_e5", 3'd1, 10'd800, 10'd800, 1'b1, 1'b1, 1'b0);
      tick(7);

      chk_val("pending", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
